// File: rtl/controlador_timer_pkg.sv
// Shared encodings for the multi-channel on/off timer.
package controlador_timer_pkg;

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        ESPERA = 2'd1,
        LIGADO = 2'd2
    } estado_t;

    localparam logic MODO_PERIODICO = 1'b0;
    localparam logic MODO_UNICO     = 1'b1;

endpackage

// File: rtl/canal_timer.sv
// One timer channel: off-phase (ESPERA), on-phase (LIGADO), periodic or one-shot.
module canal_timer
    import controlador_timer_pkg::*;
#(
    parameter int unsigned LARGURA = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic               habilita,
    input  logic               modo,
    input  logic               disparo,
    input  logic [LARGURA-1:0] intervalo_ligar,
    input  logic [LARGURA-1:0] tempo_ligado,
    output logic               saida,
    output logic               fim_ciclo,
    output logic               ocupado
);

    estado_t            estado;
    estado_t            ent_estado;
    logic [LARGURA-1:0] cnt;
    logic [LARGURA-1:0] int_lat;
    logic [LARGURA-1:0] ton_lat;
    logic               parado;
    logic               ult_int;
    logic               ult_ton;
    logic               fim_ev;
    logic               inicio_ev;
    logic               vai_ligado;
    logic               ent_saida;

    // Phase-end detection, cycle start/end events and the entry state for a new cycle.
    always_comb begin
        parado     = (int_lat == '0) && (ton_lat == '0);
        ult_int    = (int_lat != '0) && (cnt == (int_lat - LARGURA'(1)));
        ult_ton    = (ton_lat != '0) && (cnt == (ton_lat - LARGURA'(1)));
        fim_ev     = tick && (((estado == ESPERA) && ult_int && (ton_lat == '0)) ||
                              ((estado == LIGADO) && ult_ton));
        vai_ligado = tick && (estado == ESPERA) && ult_int && (ton_lat != '0);
        inicio_ev  = ((estado == OCIOSO) &&
                      ((modo == MODO_PERIODICO) || ((modo == MODO_UNICO) && disparo))) ||
                     ((estado == ESPERA) && tick && parado) ||
                     (fim_ev && (modo == MODO_PERIODICO));
        ent_saida  = 1'b0;
        ent_estado = ESPERA;
        if ((intervalo_ligar == '0) && (tempo_ligado != '0)) begin
            ent_estado = LIGADO;
            ent_saida  = 1'b1;
        end
    end

    // Channel state, latches, phase counter and registered outputs; abort beats tick events.
    always_ff @(posedge clk) begin
        if (rst) begin
            estado    <= OCIOSO;
            cnt       <= '0;
            int_lat   <= '0;
            ton_lat   <= '0;
            saida     <= 1'b0;
            fim_ciclo <= 1'b0;
            ocupado   <= 1'b0;
        end else if (!habilita) begin
            estado    <= OCIOSO;
            cnt       <= '0;
            saida     <= 1'b0;
            fim_ciclo <= 1'b0;
            ocupado   <= 1'b0;
        end else begin
            fim_ciclo <= fim_ev;
            if (inicio_ev) begin
                int_lat <= intervalo_ligar;
                ton_lat <= tempo_ligado;
                cnt     <= '0;
                estado  <= ent_estado;
                saida   <= ent_saida;
                ocupado <= 1'b1;
            end else if (vai_ligado) begin
                estado <= LIGADO;
                cnt    <= '0;
                saida  <= 1'b1;
            end else if (fim_ev) begin
                estado  <= OCIOSO;
                cnt     <= '0;
                saida   <= 1'b0;
                ocupado <= 1'b0;
            end else if (tick && (estado != OCIOSO) && !parado) begin
                cnt <= cnt + LARGURA'(1);
            end
        end
    end

endmodule

// File: rtl/controlador_timer_multicanal.sv
// Multi-channel periodic on/off generator: shared tick prescaler plus N channel timers.
module controlador_timer_multicanal #(
    parameter int unsigned N_CANAIS = 4,
    parameter int unsigned LARGURA  = 8,
    parameter int unsigned DIV_TICK = 1000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_CANAIS-1:0]           habilita,
    input  logic [N_CANAIS-1:0]           modo,
    input  logic [N_CANAIS-1:0]           disparo,
    input  logic [N_CANAIS*LARGURA-1:0]   intervalo_ligar,
    input  logic [N_CANAIS*LARGURA-1:0]   tempo_ligado,
    output logic [N_CANAIS-1:0]           saida,
    output logic [N_CANAIS-1:0]           fim_ciclo,
    output logic [N_CANAIS-1:0]           ocupado
);

    localparam int unsigned LARG_PRE = (DIV_TICK > 1) ? $clog2(DIV_TICK) : 1;
    localparam logic [LARG_PRE-1:0] PRE_MAX = LARG_PRE'(DIV_TICK - 1);

    logic [LARG_PRE-1:0] pre_cnt;
    logic                tick;

    // Tick prescaler: wraps at DIV_TICK-1; tick is decoded from the terminal count.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt <= '0;
        end else if (pre_cnt == PRE_MAX) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + LARG_PRE'(1);
        end
    end

    assign tick = (pre_cnt == PRE_MAX);

    for (genvar i = 0; i < int'(N_CANAIS); i++) begin : g_canal
        canal_timer #(
            .LARGURA(LARGURA)
        ) u_canal (
            .clk            (clk),
            .rst            (rst),
            .tick           (tick),
            .habilita       (habilita[i]),
            .modo           (modo[i]),
            .disparo        (disparo[i]),
            .intervalo_ligar(intervalo_ligar[i*LARGURA +: LARGURA]),
            .tempo_ligado   (tempo_ligado[i*LARGURA +: LARGURA]),
            .saida          (saida[i]),
            .fim_ciclo      (fim_ciclo[i]),
            .ocupado        (ocupado[i])
        );
    end

endmodule
